// File: rtl/servo_pkg.sv
// Shared types and constants for the turret aim/fire sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package servo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SLEW,
        ST_SETTLE,
        ST_FIRE,
        ST_HOLD,
        ST_EMPTY
    } state_t;

    localparam logic [1:0] DET_NONE = 2'b00;
    localparam logic [1:0] DET_NEW  = 2'b10;

    // Bits needed to hold 0..n-1; never returns less than 1.
    function automatic int unsigned width_of(input longint unsigned n);
        return (n < 64'd2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// One servo PWM output: shadow position register, width compare, output flop.
// Latency: output lags the shared frame counter by one cycle; position updates take effect next frame.
// Backpressure: none; position is sampled only at frame end so pulses are never truncated or stretched.
module servo_pwm_channel
    import servo_pkg::*;
#(
    parameter int unsigned CNT_W      = 21,
    parameter int unsigned POS_W      = 18,
    parameter int unsigned BASE_PULSE = 70000,
    parameter int unsigned RST_POS    = 0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [CNT_W-1:0] cnt,
    input  logic             frame_end,
    input  logic [POS_W-1:0] pos,
    output logic             pwm
);

    logic [POS_W-1:0] pos_sh;

    // Shadow the position at frame end and register the pulse compare.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pos_sh <= POS_W'(RST_POS);
            pwm    <= 1'b0;
        end else begin
            if (frame_end) begin
                pos_sh <= pos;
            end
            pwm <= (32'(cnt) < BASE_PULSE + 32'(pos_sh));
        end
    end

endmodule

// File: rtl/servo_turret_sequencer.sv
// Aim/fire turret sequencer: slews aim servo to detected direction, dwells, steps release servo per shot.
// Latency: aiming rises the cycle after a new detection; servo positions take effect at the next PWM frame.
// Backpressure: none; detections are ignored outside IDLE, reload is held pending until IDLE/EMPTY.
module servo_turret_sequencer
    import servo_pkg::*;
#(
    parameter int unsigned PERIOD       = 2000000,
    parameter int unsigned BASE_PULSE   = 70000,
    parameter int unsigned POS_W        = 18,
    parameter int unsigned AIM_LEFT     = 0,
    parameter int unsigned AIM_FWD      = 100000,
    parameter int unsigned AIM_RIGHT    = 200000,
    parameter int unsigned SLEW_STEP    = 25000,
    parameter int unsigned RELEASE_STEP = 50000,
    parameter int unsigned MAG_DEPTH    = 3,
    parameter int unsigned SETTLE_CYC   = 100000,
    parameter int unsigned FIRE_CYC     = 200000,
    localparam int unsigned CW          = width_of(MAG_DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [1:0]    forward_signal,
    input  logic [1:0]    left_signal,
    input  logic [1:0]    right_signal,
    input  logic          reload,
    output logic          aim_servo,
    output logic          fire_servo,
    output logic          aiming,
    output logic          mag_empty,
    output logic [CW-1:0] shot_count
);

    localparam int unsigned CNT_W    = width_of(PERIOD);
    localparam int unsigned TMR_W    = width_of(max_of(SETTLE_CYC, FIRE_CYC));
    localparam int unsigned MAX_AIM  = max_of(AIM_FWD, max_of(AIM_LEFT, AIM_RIGHT));
    localparam int unsigned FIRE_MAX = MAG_DEPTH * RELEASE_STEP;

    // Widest pulse must end inside the frame and every position must fit POS_W.
    if ((BASE_PULSE + MAX_AIM >= PERIOD) || (BASE_PULSE + FIRE_MAX >= PERIOD) ||
        (longint'(max_of(MAX_AIM, FIRE_MAX)) >= (64'd1 << POS_W))) begin : g_bad_width
        $fatal(1, "servo_turret_sequencer: BASE_PULSE + max position must be below PERIOD");
    end

    logic [CNT_W-1:0] cnt;
    logic             frame_end;
    state_t           state, state_nxt;
    logic [POS_W-1:0] target, aim_pos, fire_pos, det_pos, slew_nxt, diff;
    logic [TMR_W-1:0] tmr;
    logic             reload_pending, reload_eff;
    logic             new_det, all_none;
    logic             latch_tgt, tmr_clr, shot_inc, do_reload;

    assign frame_end  = (cnt == CNT_W'(PERIOD - 1));
    assign reload_eff = reload | reload_pending;
    assign aiming     = (state == ST_SLEW) || (state == ST_SETTLE) || (state == ST_FIRE);
    assign mag_empty  = (state == ST_EMPTY);

    // Detector priority: forward over left over right; only the "new" code starts a shot.
    always_comb begin
        new_det  = (forward_signal == DET_NEW) || (left_signal == DET_NEW) || (right_signal == DET_NEW);
        all_none = (forward_signal == DET_NONE) && (left_signal == DET_NONE) && (right_signal == DET_NONE);
        det_pos  = POS_W'(AIM_RIGHT);
        if (forward_signal == DET_NEW) begin
            det_pos = POS_W'(AIM_FWD);
        end else if (left_signal == DET_NEW) begin
            det_pos = POS_W'(AIM_LEFT);
        end
    end

    // Next aim position: one bounded step toward the target, or straight there when SLEW_STEP is 0.
    always_comb begin
        if (aim_pos < target) begin
            diff     = target - aim_pos;
            slew_nxt = (SLEW_STEP == 0 || 32'(diff) <= SLEW_STEP) ? target : aim_pos + POS_W'(SLEW_STEP);
        end else begin
            diff     = aim_pos - target;
            slew_nxt = (SLEW_STEP == 0 || 32'(diff) <= SLEW_STEP) ? target : aim_pos - POS_W'(SLEW_STEP);
        end
    end

    // Sequencer next-state; a pending reload is applied when IDLE or EMPTY is occupied or about to be.
    always_comb begin
        state_nxt = state;
        latch_tgt = 1'b0;
        tmr_clr   = 1'b0;
        shot_inc  = 1'b0;
        do_reload = 1'b0;
        case (state)
            ST_IDLE: begin
                if (new_det) begin
                    state_nxt = ST_SLEW;
                    latch_tgt = 1'b1;
                end
            end
            ST_SLEW: begin
                if (aim_pos == target) begin
                    state_nxt = ST_SETTLE;
                    tmr_clr   = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (32'(tmr) == SETTLE_CYC - 1) begin
                    state_nxt = ST_FIRE;
                    tmr_clr   = 1'b1;
                    shot_inc  = 1'b1;
                end
            end
            ST_FIRE: begin
                if (32'(tmr) == FIRE_CYC - 1) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (all_none) begin
                    state_nxt = (shot_count == CW'(MAG_DEPTH)) ? ST_EMPTY : ST_IDLE;
                end
            end
            ST_EMPTY: begin
                state_nxt = ST_EMPTY;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (reload_eff && (state == ST_IDLE || state_nxt == ST_IDLE || state_nxt == ST_EMPTY)) begin
            do_reload = 1'b1;
            if (state_nxt == ST_EMPTY) begin
                state_nxt = ST_IDLE;
            end
        end
    end

    // Frame counter, FSM state, dwell timer, positions, shot count and reload latch.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt            <= '0;
            state          <= ST_IDLE;
            tmr            <= '0;
            target         <= POS_W'(AIM_FWD);
            aim_pos        <= POS_W'(AIM_FWD);
            fire_pos       <= '0;
            shot_count     <= '0;
            reload_pending <= 1'b0;
        end else begin
            cnt   <= frame_end ? '0 : cnt + 1'b1;
            state <= state_nxt;
            if (tmr_clr) begin
                tmr <= '0;
            end else if (tmr != '1) begin
                tmr <= tmr + 1'b1;
            end
            if (latch_tgt) begin
                target <= det_pos;
            end
            if (state == ST_SLEW && frame_end && aim_pos != target) begin
                aim_pos <= slew_nxt;
            end
            if (do_reload) begin
                fire_pos   <= '0;
                shot_count <= '0;
            end else if (shot_inc) begin
                if (32'(fire_pos) + RELEASE_STEP >= FIRE_MAX) begin
                    fire_pos <= POS_W'(FIRE_MAX);
                end else begin
                    fire_pos <= fire_pos + POS_W'(RELEASE_STEP);
                end
                if (shot_count != CW'(MAG_DEPTH)) begin
                    shot_count <= shot_count + 1'b1;
                end
            end
            if (do_reload) begin
                reload_pending <= 1'b0;
            end else if (reload) begin
                reload_pending <= 1'b1;
            end
        end
    end

    servo_pwm_channel #(
        .CNT_W(CNT_W), .POS_W(POS_W), .BASE_PULSE(BASE_PULSE), .RST_POS(AIM_FWD)
    ) u_aim (
        .clock(clock), .reset_n(reset_n), .cnt(cnt), .frame_end(frame_end), .pos(aim_pos), .pwm(aim_servo)
    );

    servo_pwm_channel #(
        .CNT_W(CNT_W), .POS_W(POS_W), .BASE_PULSE(BASE_PULSE), .RST_POS(0)
    ) u_fire (
        .clock(clock), .reset_n(reset_n), .cnt(cnt), .frame_end(frame_end), .pos(fire_pos), .pwm(fire_servo)
    );

endmodule

// File: tb/tb_servo_turret_sequencer.sv
// Bench for the turret sequencer: pulse-width scoreboard plus state/output spot checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_servo_turret_sequencer;

    localparam int BASE  = 100;
    localparam int STEP  = 200;
    localparam int RSTEP = 100;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic [1:0] forward_signal = 2'b00;
    logic [1:0] left_signal = 2'b00;
    logic [1:0] right_signal = 2'b00;
    logic       reload = 1'b0;
    logic       aim_servo, fire_servo, aiming, mag_empty;
    logic [1:0] shot_count;

    int checks = 0;
    int errors = 0;
    int aim_q[$];
    int fire_q[$];
    int aim_model = 400;
    int fire_model = 0;
    int sc_model = 0;
    int aim_run = 0, fire_run = 0, aim_prev = -1, fire_prev = -1;

    servo_turret_sequencer #(
        .PERIOD(1000), .BASE_PULSE(100), .POS_W(18),
        .AIM_LEFT(0), .AIM_FWD(400), .AIM_RIGHT(800),
        .SLEW_STEP(200), .RELEASE_STEP(100), .MAG_DEPTH(3),
        .SETTLE_CYC(50), .FIRE_CYC(50)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .forward_signal(forward_signal), .left_signal(left_signal), .right_signal(right_signal),
        .reload(reload), .aim_servo(aim_servo), .fire_servo(fire_servo),
        .aiming(aiming), .mag_empty(mag_empty), .shot_count(shot_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Measure each high run; every change of pulse width must match the next expected width.
    always @(negedge clock) begin
        if (!reset_n) begin
            aim_run = 0; fire_run = 0; aim_prev = -1; fire_prev = -1;
        end else begin
            if (aim_servo) begin
                aim_run++;
            end else if (aim_run != 0) begin
                if (aim_run != aim_prev) begin
                    if (aim_q.size() == 0) chk("aim_unexpected_width", aim_run, aim_prev);
                    else chk("aim_width", aim_run, aim_q.pop_front());
                    aim_prev = aim_run;
                end
                aim_run = 0;
            end
            if (fire_servo) begin
                fire_run++;
            end else if (fire_run != 0) begin
                if (fire_run != fire_prev) begin
                    if (fire_q.size() == 0) chk("fire_unexpected_width", fire_run, fire_prev);
                    else chk("fire_width", fire_run, fire_q.pop_front());
                    fire_prev = fire_run;
                end
                fire_run = 0;
            end
        end
    end

    function automatic logic [1:0] track(input logic [1:0] c);
        return (c == 2'b10) ? 2'b01 : c;
    endfunction

    task automatic push_slew(input int tgt);
        int pos;
        pos = aim_model;
        while (pos != tgt) begin
            if (pos < tgt) pos = (tgt - pos > STEP) ? pos + STEP : tgt;
            else           pos = (pos - tgt > STEP) ? pos - STEP : tgt;
            aim_q.push_back(BASE + pos);
        end
        aim_model = tgt;
    endtask

    // One complete shot: detect, slew, settle, fire, hold, then clear the codes.
    task automatic shot(input logic [1:0] f, input logic [1:0] l, input logic [1:0] r,
                        input int tgt, input bit rld, input bit noise);
        bit got;
        @(negedge clock);
        forward_signal = f; left_signal = l; right_signal = r;
        push_slew(tgt);
        fire_model += RSTEP;
        fire_q.push_back(BASE + fire_model);
        @(negedge clock);
        chk("aiming_on_detect", 32'(aiming), 1);
        forward_signal = track(f); left_signal = track(l); right_signal = track(r);
        if (noise) right_signal = 2'b10;
        got = 1'b0;
        for (int i = 0; i < 10000 && !got; i++) begin
            @(negedge clock);
            if (int'(shot_count) == sc_model + 1) got = 1'b1;
        end
        chk("shot_count_step", 32'(got), 1);
        sc_model++;
        chk("aiming_in_fire", 32'(aiming), 1);
        if (rld) begin
            reload = 1'b1;
            @(negedge clock);
            reload = 1'b0;
        end
        repeat (2100) @(negedge clock);
        chk("aiming_in_hold", 32'(aiming), 0);
        chk("mag_empty_in_hold", 32'(mag_empty), 0);
        forward_signal = 2'b00; left_signal = 2'b00; right_signal = 2'b00;
        repeat (3) @(negedge clock);
    endtask

    task automatic pulse_reload();
        @(negedge clock);
        reload = 1'b1;
        @(negedge clock);
        reload = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    initial begin
        // Reset values
        #1 reset_n = 1'b0;
        #2;
        chk("rst_aim_servo", 32'(aim_servo), 0);
        chk("rst_fire_servo", 32'(fire_servo), 0);
        chk("rst_aiming", 32'(aiming), 0);
        chk("rst_mag_empty", 32'(mag_empty), 0);
        chk("rst_shot_count", 32'(shot_count), 0);
        aim_q.push_back(500);
        fire_q.push_back(100);
        repeat (3) @(negedge clock);
        #2 reset_n = 1'b1;

        // Idle frames: aim 500, fire 100, rover free to move
        repeat (2100) @(negedge clock);
        chk("idle_aiming", 32'(aiming), 0);
        chk("idle_aim_seen", aim_q.size(), 0);
        chk("idle_fire_seen", fire_q.size(), 0);

        // Left shot
        shot(2'b00, 2'b10, 2'b00, 0, 1'b0, 1'b0);
        chk("left_shot_count", 32'(shot_count), 1);

        // Finish the magazine, then a further detection must be ignored
        shot(2'b10, 2'b00, 2'b00, 400, 1'b0, 1'b0);
        shot(2'b00, 2'b00, 2'b10, 800, 1'b0, 1'b0);
        chk("empty_mag_empty", 32'(mag_empty), 1);
        chk("empty_shot_count", 32'(shot_count), 3);
        @(negedge clock);
        forward_signal = 2'b10;
        repeat (5) @(negedge clock);
        chk("empty_ignores_detect", 32'(aiming), 0);
        chk("empty_still_empty", 32'(mag_empty), 1);
        forward_signal = 2'b00;

        // Reload from EMPTY
        pulse_reload();
        chk("reload_mag_empty", 32'(mag_empty), 0);
        chk("reload_shot_count", 32'(shot_count), 0);
        sc_model = 0; fire_model = 0;
        fire_q.push_back(BASE);
        repeat (2100) @(negedge clock);
        chk("reload_fire_seen", fire_q.size(), 0);

        // Forward beats right; a later right detection during the shot changes nothing
        shot(2'b10, 2'b00, 2'b10, 400, 1'b0, 1'b1);
        chk("prio_aim_done", aim_q.size(), 0);
        chk("prio_shot_count", 32'(shot_count), 1);

        // Reload arriving during FIRE of the third shot lands on leaving HOLD
        shot(2'b00, 2'b10, 2'b00, 0, 1'b0, 1'b0);
        shot(2'b00, 2'b00, 2'b10, 800, 1'b1, 1'b0);
        chk("pend_reload_mag_empty", 32'(mag_empty), 0);
        chk("pend_reload_shot_count", 32'(shot_count), 0);
        sc_model = 0; fire_model = 0;
        fire_q.push_back(BASE);
        repeat (2100) @(negedge clock);
        chk("pend_reload_fire_seen", fire_q.size(), 0);

        // Reset in the middle of a slew
        @(negedge clock);
        left_signal = 2'b10;
        push_slew(0);
        @(negedge clock);
        left_signal = 2'b01;
        repeat (1500) @(negedge clock);
        chk("mid_slew_aiming", 32'(aiming), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_aim_servo", 32'(aim_servo), 0);
        chk("midrst_fire_servo", 32'(fire_servo), 0);
        chk("midrst_aiming", 32'(aiming), 0);
        aim_q.delete();
        fire_q.delete();
        aim_q.push_back(500);
        fire_q.push_back(100);
        aim_model = 400; fire_model = 0; sc_model = 0;
        left_signal = 2'b00;
        repeat (3) @(negedge clock);
        #2 reset_n = 1'b1;
        repeat (2500) @(negedge clock);
        chk("post_rst_aiming", 32'(aiming), 0);
        chk("post_rst_shot_count", 32'(shot_count), 0);
        chk("post_rst_aim_seen", aim_q.size(), 0);
        chk("post_rst_fire_seen", fire_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
